// File: rtl/i2c_target_responder.sv
// i2c_target_responder: I2C target with glitch-filtered inputs, 7-bit address match,
// register pointer and auto-incrementing register writes/reads over a local register port.
module i2c_target_responder #(
  parameter logic [6:0] pDevAdrs = 7'h50,
  parameter int         pFiltLen = 3
) (
  input  logic       iSysClk,
  input  logic       iSysRst,
  input  logic       iI2CScl,
  input  logic       iI2CSda,
  output logic       oI2CSdaOe,
  output logic [7:0] oRegAdrs,
  output logic [7:0] oRegWd,
  output logic       oRegWe,
  input  logic [7:0] iRegRd,
  output logic       oBusy
);
  localparam int CW = $clog2(pFiltLen + 1);
  localparam logic [CW-1:0] LIM = CW'(pFiltLen - 1);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  // index 0 = SCL, index 1 = SDA
  logic [1:0] s1_q, s2_q, f_q, f_d, chg;
  logic [1:0][CW-1:0] fcnt_q, fcnt_d;
  state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d, ptr_q, ptr_d, wd_q, wd_d;
  logic oe_q, oe_d, we_q, we_d, busy_q, busy_d;
  logic scl_rise, scl_fall, start, stop, addr_hit;
  logic [7:0] rx_byte;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      chg[i] = s2_q[i] != f_q[i] && fcnt_q[i] == LIM;
      fcnt_d[i] = (s2_q[i] == f_q[i] || chg[i]) ? '0 : fcnt_q[i] + CW'(1);
    end
    f_d = f_q ^ chg;
  end
  assign scl_rise = chg[0] & ~f_q[0];
  assign scl_fall = chg[0] & f_q[0];
  assign start    = chg[1] & f_q[1] & f_q[0];
  assign stop     = chg[1] & ~f_q[1] & f_q[0];
  assign rx_byte  = {sr_q[6:0], f_q[1]};
  assign addr_hit = rx_byte[7:1] == pDevAdrs && |rx_byte[7:1];
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    we_d      = 1'b0;
    wd_d      = wd_q;
    busy_d    = busy_q;
    if (stop) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start) begin
      state_d   = ADDR;
      oe_d      = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, REG, WDATA: begin
          sr_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (state_q == ADDR) begin
              state_d   = addr_hit ? ADDR_ACK : IGNORE;
              busy_d    = addr_hit;
              bit_cnt_d = addr_hit ? 4'd8 : 4'd0;
            end else if (state_q == REG) begin
              ptr_d   = rx_byte;
              state_d = REG_ACK;
            end else begin
              we_d    = 1'b1;
              wd_d    = rx_byte;
              ptr_d   = ptr_q + 8'd1;
              state_d = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          ptr_d     = bit_cnt_q == 4'd7 ? ptr_q + 8'd1 : ptr_q;
        end
        RDATA_ACK: begin
          state_d   = f_q[1] ? IGNORE : RDATA_ACK;
          bit_cnt_d = f_q[1] ? bit_cnt_q : 4'd0;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        // bit_cnt 8 marks the 8th fall (start driving ACK), 0 the 9th fall (end of slot)
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (bit_cnt_q == 4'd8) begin
            oe_d      = 1'b1;
            bit_cnt_d = 4'd0;
          end else if (state_q == ADDR_ACK && sr_q[0]) begin
            state_d = RDATA;
            sr_d    = iRegRd;
            oe_d    = ~iRegRd[7];
          end else begin
            oe_d    = 1'b0;
            state_d = state_q == ADDR_ACK ? REG : WDATA;
          end
        end
        RDATA: begin
          state_d = bit_cnt_q == 4'd8 ? RDATA_ACK : RDATA;
          sr_d    = bit_cnt_q == 4'd8 ? sr_q : {sr_q[6:0], 1'b0};
          oe_d    = bit_cnt_q == 4'd8 ? 1'b0 : ~sr_q[6];
        end
        RDATA_ACK: begin
          if (bit_cnt_q == 4'd0) begin
            state_d = RDATA;
            sr_d    = iRegRd;
            oe_d    = ~iRegRd[7];
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      f_q       <= 2'b11;
      fcnt_q    <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      sr_q      <= 8'd0;
      ptr_q     <= 8'd0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      wd_q      <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      s1_q      <= {iI2CSda, iI2CScl};
      s2_q      <= s1_q;
      f_q       <= f_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
    end
  end
  // pointer has already advanced during the write strobe
  assign oRegAdrs  = we_q ? ptr_q - 8'd1 : ptr_q;
  assign oRegWd    = wd_q;
  assign oRegWe    = we_q;
  assign oI2CSdaOe = oe_q;
  assign oBusy     = busy_q;
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder: table-driven I2C controller transactions against the target,
// plus hand-written reset and SDA-timing sequences.
module tb_i2c_target_responder;
  localparam int H = 16;
  typedef enum logic [2:0] {OP_S, OP_RS, OP_P, OP_W, OP_R, OP_PART} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       glitch;
    logic       exp_ack;
    logic [7:0] exp_rd;
    logic       exp_busy;
    logic [7:0] exp_ptr;
    int         exp_wes;
    logic [7:0] exp_wa;
    logic [7:0] exp_wd;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_drv = 1'b1;
  logic oe, we, busy, sda_line;
  logic [7:0] adrs, wd_o, rd;
  int checks = 0, fails = 0;
  int we_cnt = 0;
  logic [7:0] we_a = 8'h00, we_d = 8'h00;
  logic [3:0] scl_hist = 4'hF;
  logic oe_prev = 1'b0;
  int tfail = 0;
  vec_t vq[$];
  assign sda_line = sda_drv & ~oe;
  assign rd = adrs ^ 8'hFF;
  i2c_target_responder dut (
    .iSysClk(clk), .iSysRst(rst), .iI2CScl(scl), .iI2CSda(sda_line),
    .oI2CSdaOe(oe), .oRegAdrs(adrs), .oRegWd(wd_o), .oRegWe(we),
    .iRegRd(rd), .oBusy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (we) begin
      we_cnt <= we_cnt + 1;
      we_a   <= adrs;
      we_d   <= wd_o;
    end
  end
  always @(negedge clk) begin
    scl_hist <= {scl_hist[2:0], scl};
    oe_prev  <= oe;
    if (!rst && oe !== oe_prev && (scl || scl_hist != 4'h0)) begin
      tfail <= tfail + 1;
      $display("FAIL sda_oe_timing: oe became %b at %0t while SCL was high, required SCL low", oe, $time);
    end
  end
  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic bus_start();
    sda_drv = 1'b1; hw(H);
    scl = 1'b1; hw(H);
    sda_drv = 1'b0; hw(H);
    scl = 1'b0; hw(H/2);
  endtask
  task automatic bus_stop();
    sda_drv = 1'b0; hw(H);
    scl = 1'b1; hw(H);
    sda_drv = 1'b1; hw(H);
  endtask
  task automatic send_bits(input logic [7:0] b, input int n, input logic g);
    for (int i = 0; i < n; i++) begin
      sda_drv = b[7-i]; hw(H);
      scl = 1'b1; hw(H/2);
      if (g && i == 0) begin
        sda_drv = ~sda_drv; hw(1);
        sda_drv = ~sda_drv;
      end
      hw(H/2);
      scl = 1'b0; hw(H/2);
    end
  endtask
  task automatic write_byte(input logic [7:0] b, input logic g, output logic ack);
    send_bits(b, 8, g);
    sda_drv = 1'b1; hw(H);
    scl = 1'b1; hw(H/2);
    ack = oe;
    hw(H/2);
    scl = 1'b0; hw(H/2);
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_drv = 1'b1; hw(H);
      scl = 1'b1; hw(H/2);
      d = {d[6:0], sda_line};
      hw(H/2);
      scl = 1'b0; hw(H/2);
    end
    sda_drv = mack; hw(H);
    scl = 1'b1; hw(H);
    scl = 1'b0; hw(H/2);
  endtask
  function automatic vec_t mk(op_t op, logic [7:0] d, logic g, logic a, logic [7:0] r,
                              logic bz, logic [7:0] p, int w, logic [7:0] wa, logic [7:0] wdv);
    vec_t v;
    v.op = op; v.data = d; v.glitch = g; v.exp_ack = a; v.exp_rd = r;
    v.exp_busy = bz; v.exp_ptr = p; v.exp_wes = w; v.exp_wa = wa; v.exp_wd = wdv;
    return v;
  endfunction
  initial begin
    logic ack;
    logic [7:0] b;
    // write two bytes at 0x10
    vq.push_back(mk(OP_S,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'h00));
    vq.push_back(mk(OP_W,    8'hA0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 0, 8'h00, 8'h00));
    vq.push_back(mk(OP_W,    8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 8'h10, 0, 8'h00, 8'h00));
    vq.push_back(mk(OP_W,    8'h5A, 1'b0, 1'b1, 8'h00, 1'b1, 8'h11, 1, 8'h10, 8'h5A));
    vq.push_back(mk(OP_W,    8'hC3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h12, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_P,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 2, 8'h11, 8'hC3));
    // random read with repeated START
    vq.push_back(mk(OP_S,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'hA0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h12, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'h20, 1'b0, 1'b1, 8'h00, 1'b1, 8'h20, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_RS,   8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'hA1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h20, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_R,    8'h00, 1'b0, 1'b0, 8'hDF, 1'b1, 8'h21, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_R,    8'h01, 1'b0, 1'b0, 8'hDE, 1'b1, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_P,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    // address mismatch
    vq.push_back(mk(OP_S,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'hA4, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_P,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    // pointer wrap
    vq.push_back(mk(OP_S,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'hA0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h22, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF, 2, 8'h11, 8'hC3));
    vq.push_back(mk(OP_W,    8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 3, 8'hFF, 8'h01));
    vq.push_back(mk(OP_W,    8'h02, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 4, 8'h00, 8'h02));
    vq.push_back(mk(OP_P,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 4, 8'h00, 8'h02));
    // SDA glitches while SCL high, then STOP after 5 data bits
    vq.push_back(mk(OP_S,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 4, 8'h00, 8'h02));
    vq.push_back(mk(OP_W,    8'hA0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 4, 8'h00, 8'h02));
    vq.push_back(mk(OP_W,    8'h30, 1'b1, 1'b1, 8'h00, 1'b1, 8'h30, 4, 8'h00, 8'h02));
    vq.push_back(mk(OP_W,    8'h85, 1'b1, 1'b1, 8'h00, 1'b1, 8'h31, 5, 8'h30, 8'h85));
    vq.push_back(mk(OP_PART, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 8'h31, 5, 8'h30, 8'h85));
    vq.push_back(mk(OP_P,    8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h31, 5, 8'h30, 8'h85));
    hw(3);
    check8("rst_oe",   {7'd0, oe},   8'h00);
    check8("rst_we",   {7'd0, we},   8'h00);
    check8("rst_adrs", adrs,         8'h00);
    check8("rst_wd",   wd_o,         8'h00);
    check8("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    hw(10);
    foreach (vq[k]) begin
      case (vq[k].op)
        OP_S, OP_RS: bus_start();
        OP_P:        bus_stop();
        OP_W: begin
          write_byte(vq[k].data, vq[k].glitch, ack);
          check8($sformatf("v%0d_ack", k), {7'd0, ack}, {7'd0, vq[k].exp_ack});
        end
        OP_R: begin
          read_byte(vq[k].data[0], b);
          check8($sformatf("v%0d_rdata", k), b, vq[k].exp_rd);
        end
        default: send_bits(vq[k].data, 5, 1'b0);
      endcase
      check8($sformatf("v%0d_busy", k), {7'd0, busy}, {7'd0, vq[k].exp_busy});
      check8($sformatf("v%0d_ptr", k), adrs, vq[k].exp_ptr);
      check8($sformatf("v%0d_we_count", k), 8'(we_cnt), 8'(vq[k].exp_wes));
      check8($sformatf("v%0d_we_adrs", k), we_a, vq[k].exp_wa);
      check8($sformatf("v%0d_we_data", k), we_d, vq[k].exp_wd);
    end
    // reset asserted while the address ACK is being driven
    bus_start();
    send_bits(8'hA0, 8, 1'b0);
    check8("ack_drive", {7'd0, oe}, 8'h01);
    #3 rst = 1'b1;
    #1 check8("rst_async_release", {7'd0, oe}, 8'h00);
    sda_drv = 1'b1; hw(2);
    scl = 1'b1; hw(4);
    check8("rst2_busy", {7'd0, busy}, 8'h00);
    check8("rst2_adrs", adrs, 8'h00);
    check8("rst2_wd",   wd_o, 8'h00);
    check8("rst2_we",   {7'd0, we}, 8'h00);
    rst = 1'b0;
    hw(20);
    check8("we_total", 8'(we_cnt), 8'd5);
    check8("sda_oe_timing_violations", 8'(tfail), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) that answers the I2CBlock controller on the same SCL/SDA pair.
- Samples SCL/SDA on iSysClk and detects START, repeated START and STOP.
- Matches a 7-bit device address, ACKs, takes an 8-bit register pointer, then performs auto-incrementing register writes or reads.
- Sits beside sensor/peripheral models on the board bus and exposes a simple synchronous register port to local logic.

Parameters:
- pDevAdrs, 7'h50: 7-bit target address this block answers to.
- pFiltLen, 3: number of consecutive equal samples needed to accept a new SCL/SDA level (glitch filter).

Ports:
- iSysClk  in  1  system clock; all logic on the rising edge.
- iSysRst  in  1  reset, asynchronous, active-high.
- iI2CScl  in  1  SCL line level; the block never drives SCL (no clock stretching).
- iI2CSda  in  1  SDA line level.
- oI2CSdaOe  out  1  1 = pull SDA low (open drain); the top level builds the tri-state.
- oRegAdrs  out  8  register address for the current access.
- oRegWd  out  8  write data, valid while oRegWe=1.
- oRegWe  out  1  one-cycle write strobe.
- iRegRd  in  8  read data for oRegAdrs, combinational from local logic.
- oBusy  out  1  1 from an address-matched START until STOP.

Behaviour:
- Reset values: oI2CSdaOe=0, oRegWe=0, oRegAdrs=0, oRegWd=0, oBusy=0; state=IDLE; pointer=0.
- Reset asserted mid-transfer releases SDA in the same cycle.
- Input path: 2-FF synchronizer, then a pFiltLen-sample filter.
  - "SCL rise/fall" means a change of the filtered level.
  - Total input latency is 2+pFiltLen cycles.
- START/STOP detection:
  - START: filtered SDA 1->0 while filtered SCL=1.
  - STOP: filtered SDA 0->1 while filtered SCL=1.
  - Both take priority over bit processing in every state.
- Bit timing: data is shifted in MSB first on SCL rise. oI2CSdaOe changes only on SCL fall, never while SCL=1.
- Bit counter: 0..8; the 9th clock is the ACK slot.
- State machine:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: after 8 bits compare [7:1] with pDevAdrs.
    - Match: go to ADDR_ACK and set oBusy=1.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: drive SDA low from the 8th SCL fall to the 9th SCL fall.
    - R/W=0: go to REG.
    - R/W=1: go to RDATA and load the shifter from iRegRd at that 9th SCL fall.
  - REG: after 8 bits, pointer is set to the received byte. Go to REG_ACK (ACK), then WDATA.
  - WDATA: after 8 bits, oRegAdrs=pointer and oRegWd=byte, with oRegWe=1 for exactly one cycle on the 8th SCL rise.
    - Pointer increments (8-bit, 8'hFF wraps to 8'h00).
    - Go to WDATA_ACK (ACK), then back to WDATA.
  - RDATA: drive oI2CSdaOe = ~shifter[7] on each SCL fall for 8 bits, then release SDA for the controller ACK.
    - Pointer increments after the byte (same 8-bit wrap).
  - RDATA_ACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): reload from iRegRd at oRegAdrs=pointer on the next SCL fall, then RDATA.
    - 1 (NACK): go to IGNORE with SDA released.
  - IGNORE: SDA released; leave only on START (to ADDR) or STOP (to IDLE).
- oRegAdrs follows pointer continuously outside the oRegWe pulse.
- Repeated START:
  - Go to ADDR and keep the pointer, so a register-pointer write followed by a read works.
  - Release SDA immediately.
  - oBusy stays 1 until the address check.
- STOP in any state: go to IDLE, oI2CSdaOe=0, oBusy=0 the next cycle, bit counter cleared.
  - A STOP inside a partial byte discards that byte, with no oRegWe.
- START or STOP while driving SDA: release first; no glitch on oRegWe.
- General call (address 0) is not answered.

Test Plan:
- Write two bytes: START, 0xA0 (0x50 W), 0x10, 0x5A, 0xC3, STOP -> three ACKs plus a data ACK; oRegWe pulses twice with (0x10,0x5A) then (0x11,0xC3); oBusy falls after STOP.
- Random read with repeated START: START, 0xA0, 0x20, rSTART, 0xA1, then read 2 bytes with ACK then NACK, STOP; iRegRd=adrs^0xFF -> SDA carries 0xDF, 0xDE; pointer ends at 0x22.
- Address mismatch: START, 0xA4, then bytes, STOP -> oI2CSdaOe never 1; no oRegWe; oBusy stays 0.
- Pointer wrap: write at pointer 0xFF with data 0x01, 0x02 -> writes land at 0xFF then 0x00.
- Glitch and abort:
  - A 1-cycle SDA pulse while SCL=1 is ignored (no false START/STOP).
  - A STOP after 5 data bits gives no oRegWe.
  - iSysRst asserted during the ADDR_ACK drive gives oI2CSdaOe=0 at once.
- Timing check: oI2CSdaOe transitions only while the filtered SCL is 0, across all of the above.
